tap_ctrl: RTL and testbench

//  IEEE 1149.1 TAP controller driving the boundary-scan register (BSR) chain.

---
 rtl/tap_ctrl_if.sv | 35 +++
 rtl/tap_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_tap_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_ctrl_if.sv
// -----------------------------------------------------------------------------
// tap_ctrl_if
//   JTAG pin bundle between the external test access port and the TAP
//   controller. TCK and TRST stay plain ports on the controller itself.
//
//   Signals:
//     TMS     test mode select, driven by the tester, sampled on posedge TCK
//     TDI     serial data in, driven by the tester
//     TDO     serial data out, driven by the controller on negedge TCK
//     tdo_en  TDO output enable, driven by the controller
//
//   Modports:
//     master  tester / pin side  (drives TMS, TDI)
//     slave   TAP controller     (drives TDO, tdo_en)
// -----------------------------------------------------------------------------
interface tap_ctrl_if;
    logic TMS;
    logic TDI;
    logic TDO;
    logic tdo_en;

    modport master (
        output TMS,
        output TDI,
        input  TDO,
        input  tdo_en
    );

    modport slave (
        input  TMS,
        input  TDI,
        output TDO,
        output tdo_en
    );
endinterface

// File: rtl/tap_ctrl.sv
// -----------------------------------------------------------------------------
// tap_ctrl
//   IEEE 1149.1 TAP controller for the boundary-scan register (BSR) chain.
//   Decodes TMS into the 16-state TAP FSM, holds the instruction register,
//   produces capture/shift/update strobes plus select/mode for the BSR, owns
//   the bypass register (and optionally the 32-bit ID register) and muxes TDO.
//
//   Optional feature macro: TAP_IDCODE_EN
//     defined     -> 32-bit ID register, OP_IDCODE decoded, reset instr = IDCODE
//     not defined -> no ID register, OP_IDCODE behaves as BYPASS,
//                    reset instr = BYPASS (all ones)
//
//   Ports:
//     TCK         in   test clock
//     TRST        in   test reset, asynchronous, active-low
//     jtag        if   slave side of tap_ctrl_if (TMS, TDI in; TDO, tdo_en out)
//     bsr_tdo     in   serial out of the last BSR cell
//     dr_capture  out  state == CAPTURE_DR
//     dr_shift    out  state == SHIFT_DR
//     dr_update   out  state == UPDATE_DR
//     bsr_select  out  current instruction is EXTEST or SAMPLE/PRELOAD
//     mode        out  1 = BSR drives pins/core (EXTEST only)
//     tlr_reset   out  state == TEST_LOGIC_RESET
//     ir_out      out  current (updated) instruction
// -----------------------------------------------------------------------------
module tap_ctrl #(
    parameter int unsigned     IR_W       = 4,
    parameter logic [IR_W-1:0] OP_EXTEST  = 'h0,
    parameter logic [IR_W-1:0] OP_SAMPLE  = 'h1,
    parameter logic [IR_W-1:0] OP_IDCODE  = 'h2,
    parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001
) (
    input  logic            TCK,
    input  logic            TRST,
    tap_ctrl_if.slave       jtag,
    input  logic            bsr_tdo,
    output logic            dr_capture,
    output logic            dr_shift,
    output logic            dr_update,
    output logic            bsr_select,
    output logic            mode,
    output logic            tlr_reset,
    output logic [IR_W-1:0] ir_out
);

    typedef enum logic [3:0] {
        TLR        = 4'h0,
        RTI        = 4'h1,
        SEL_DR     = 4'h2,
        CAP_DR     = 4'h3,
        SHIFT_DR   = 4'h4,
        EXIT1_DR   = 4'h5,
        PAUSE_DR   = 4'h6,
        EXIT2_DR   = 4'h7,
        UPD_DR     = 4'h8,
        SEL_IR     = 4'h9,
        CAP_IR     = 4'hA,
        SHIFT_IR   = 4'hB,
        EXIT1_IR   = 4'hC,
        PAUSE_IR   = 4'hD,
        EXIT2_IR   = 4'hE,
        UPD_IR     = 4'hF
    } tap_state_e;

`ifdef TAP_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RST = '1;
`endif

    // Fixed "01" in the two LSBs lets a debugger verify IR chain integrity.
    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

    tap_state_e      state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] ir_sr_q, ir_sr_d;
    logic            bypass_q, bypass_d;
    logic            tdo_q, tdo_d;
    logic            tdo_en_q, tdo_en_d;

    logic            sel_bsr;
    logic            sel_extest;
    logic            sel_idcode;
    logic            sel_bypass;

`ifdef TAP_IDCODE_EN
    logic [31:0]     id_sr_q, id_sr_d;
`else
    // Keeps the ID-related parameters referenced when the feature is off.
    logic            unused_cfg;
    assign unused_cfg = ^{OP_IDCODE, IDCODE_VAL};
`endif

    // -------------------------------------------------------------------------
    // Instruction decode. Anything not recognised behaves as BYPASS.
    // -------------------------------------------------------------------------
    assign sel_extest = (ir_q == OP_EXTEST);
    assign sel_bsr    = sel_extest || (ir_q == OP_SAMPLE);
`ifdef TAP_IDCODE_EN
    assign sel_idcode = (ir_q == OP_IDCODE) && !sel_bsr;
`else
    assign sel_idcode = 1'b0;
`endif
    assign sel_bypass = !sel_bsr && !sel_idcode;

    // -------------------------------------------------------------------------
    // TAP FSM next-state logic (1149.1 TMS table)
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = jtag.TMS ? TLR      : RTI;
            RTI:      state_d = jtag.TMS ? SEL_DR   : RTI;
            SEL_DR:   state_d = jtag.TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = jtag.TMS ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = jtag.TMS ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = jtag.TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = jtag.TMS ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = jtag.TMS ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = jtag.TMS ? SEL_DR   : RTI;
            SEL_IR:   state_d = jtag.TMS ? TLR      : CAP_IR;
            CAP_IR:   state_d = jtag.TMS ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = jtag.TMS ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = jtag.TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = jtag.TMS ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = jtag.TMS ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = jtag.TMS ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // -------------------------------------------------------------------------
    // Instruction, IR shift, bypass and ID register next values
    // -------------------------------------------------------------------------
    always_comb begin
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        bypass_d = bypass_q;

        // TLR keeps forcing the reset instruction for as long as we sit there.
        if (state_q == TLR) begin
            ir_d = IR_RST;
        end else if (state_q == UPD_IR) begin
            ir_d = ir_sr_q;
        end

        if (state_q == CAP_IR) begin
            ir_sr_d = IR_CAPTURE;
        end else if (state_q == SHIFT_IR) begin
            ir_sr_d = {jtag.TDI, ir_sr_q[IR_W-1:1]};
        end

        if (state_q == CAP_DR) begin
            bypass_d = 1'b0;
        end else if ((state_q == SHIFT_DR) && sel_bypass) begin
            bypass_d = jtag.TDI;
        end
    end

`ifdef TAP_IDCODE_EN
    always_comb begin
        id_sr_d = id_sr_q;
        if ((state_q == CAP_DR) && sel_idcode) begin
            id_sr_d = IDCODE_VAL;
        end else if ((state_q == SHIFT_DR) && sel_idcode) begin
            id_sr_d = {jtag.TDI, id_sr_q[31:1]};
        end
    end
`endif

    // -------------------------------------------------------------------------
    // TDO mux. Outside the shift states TDO keeps its last value and the
    // enable drops.
    // -------------------------------------------------------------------------
    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        if (state_q == SHIFT_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (state_q == SHIFT_DR) begin
            tdo_en_d = 1'b1;
            if (sel_bsr) begin
                tdo_d = bsr_tdo;
`ifdef TAP_IDCODE_EN
            end else if (sel_idcode) begin
                tdo_d = id_sr_q[0];
`endif
            end else begin
                tdo_d = bypass_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Posedge TCK state
    // -------------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q  <= TLR;
            ir_q     <= IR_RST;
            ir_sr_q  <= '0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
        end
    end

`ifdef TAP_IDCODE_EN
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            id_sr_q <= '0;
        end else begin
            id_sr_q <= id_sr_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Negedge TCK output launch: gives the receiver half a cycle of setup.
    // -------------------------------------------------------------------------
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign jtag.TDO    = tdo_q;
    assign jtag.tdo_en = tdo_en_q;

    assign dr_capture  = (state_q == CAP_DR);
    assign dr_shift    = (state_q == SHIFT_DR);
    assign dr_update   = (state_q == UPD_DR);
    assign tlr_reset   = (state_q == TLR);
    assign bsr_select  = sel_bsr;
    assign mode        = sel_extest;
    assign ir_out      = ir_q;

endmodule

// File: tb/tb_tap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tap_ctrl
//   Directed-vector bench for tap_ctrl. Inputs change 1 time unit after the
//   falling TCK edge; outputs are sampled at that same point, after TDO has
//   been launched and after the preceding rising edge has moved the FSM.
// -----------------------------------------------------------------------------
module tb_tap_ctrl;

    localparam int IR_W = 4;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0] IR_RST = 4'h2;
`else
    localparam logic [3:0] IR_RST = 4'hF;
`endif
    localparam logic [31:0] ID_VAL = 32'h1000_0001;

    logic            TCK;
    logic            TRST;
    logic            bsr_tdo;
    logic            dr_capture;
    logic            dr_shift;
    logic            dr_update;
    logic            bsr_select;
    logic            mode;
    logic            tlr_reset;
    logic [IR_W-1:0] ir_out;

    int n_chk  = 0;
    int n_pass = 0;

    tap_ctrl_if jtag ();

    tap_ctrl #(
        .IR_W       (IR_W),
        .OP_EXTEST  (4'h0),
        .OP_SAMPLE  (4'h1),
        .OP_IDCODE  (4'h2),
        .IDCODE_VAL (ID_VAL)
    ) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .jtag       (jtag),
        .bsr_tdo    (bsr_tdo),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .bsr_select (bsr_select),
        .mode       (mode),
        .tlr_reset  (tlr_reset),
        .ir_out     (ir_out)
    );

    initial TCK = 1'b0;
    always #10 TCK = ~TCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One TCK cycle: present TMS/TDI, let the rising and falling edges pass.
    task automatic tck(input logic tms, input logic tdi);
        jtag.TMS = tms;
        jtag.TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    // RTI -> shift op into IR (LSB first) -> UPDATE_IR -> RTI.
    // rb collects the bits seen on TDO while shifting.
    task automatic ir_load(input logic [3:0] op, output logic [3:0] rb);
        tck(1'b1, 1'b0);  // SEL_DR
        tck(1'b1, 1'b0);  // SEL_IR
        tck(1'b0, 1'b0);  // CAP_IR
        tck(1'b0, 1'b0);  // SHIFT_IR
        for (int i = 0; i < 4; i++) begin
            rb[i] = jtag.TDO;
            tck(i == 3, op[i]);
        end
        tck(1'b1, 1'b0);  // UPD_IR
        tck(1'b0, 1'b0);  // RTI, IR updated on this edge
    endtask

    // RTI -> n-bit DR scan -> RTI. dout[i] is TDO before shifting din[i].
    task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        tck(1'b1, 1'b0);  // SEL_DR
        tck(1'b0, 1'b0);  // CAP_DR
        tck(1'b0, 1'b0);  // SHIFT_DR
        for (int i = 0; i < n; i++) begin
            dout[i] = jtag.TDO;
            tck(i == n - 1, din[i]);
        end
        tck(1'b1, 1'b0);  // UPD_DR
        tck(1'b0, 1'b0);  // RTI
    endtask

    logic [3:0]  rb;
    logic [63:0] dout;
    int          shift_cnt;

    initial begin
        TRST     = 1'b0;
        jtag.TMS = 1'b1;
        jtag.TDI = 1'b0;
        bsr_tdo  = 1'b0;
        #25;

        // Reset state
        chk("rst_tlr",     tlr_reset,   1'b1);
        chk("rst_ir",      ir_out,      IR_RST);
        chk("rst_tdo",     jtag.TDO,    1'b0);
        chk("rst_tdo_en",  jtag.tdo_en, 1'b0);
        chk("rst_strobes", {dr_capture, dr_shift, dr_update}, 3'b000);
        chk("rst_sel",     {bsr_select, mode}, 2'b00);
        TRST = 1'b1;

        tck(1'b1, 1'b0);
        chk("tlr_hold", tlr_reset, 1'b1);
        tck(1'b0, 1'b0);
        chk("tlr_to_rti", tlr_reset, 1'b0);
        chk("rti_ir", ir_out, IR_RST);

        // Reset instruction scan: ID register or bypass
`ifdef TAP_IDCODE_EN
        dr_scan(32, 64'h0, dout);
        chk("idcode_scan", dout[31:0], ID_VAL);
`else
        // bits sent 1,0,1,1,0,0,1,1 then a flush 0
        dr_scan(9, 64'h0CD, dout);
        chk("rst_bypass_scan", dout[8:0], 9'b110011010);
`endif

        // Five TMS=1 from PAUSE_IR
        tck(1'b1, 1'b0);  // SEL_DR
        tck(1'b1, 1'b0);  // SEL_IR
        tck(1'b0, 1'b0);  // CAP_IR
        tck(1'b1, 1'b0);  // EXIT1_IR
        tck(1'b0, 1'b0);  // PAUSE_IR
        tck(1'b1, 1'b0);  // EXIT2_IR
        tck(1'b1, 1'b0);  // UPD_IR
        tck(1'b1, 1'b0);  // SEL_DR, IR <= captured 0001 (SAMPLE)
        chk("upd_captured_ir", ir_out, 4'h1);
        chk("upd_captured_sel", bsr_select, 1'b1);
        tck(1'b1, 1'b0);  // SEL_IR
        chk("four_ones_not_tlr", tlr_reset, 1'b0);
        tck(1'b1, 1'b0);  // TLR
        chk("five_ones_tlr", tlr_reset, 1'b1);
        tck(1'b1, 1'b0);  // TLR, IR forced
        chk("tlr_forces_ir", ir_out, IR_RST);
        tck(1'b0, 1'b0);  // RTI
        chk("back_to_rti", tlr_reset, 1'b0);

        // EXTEST load with capture read-back
        ir_load(4'h0, rb);
        chk("extest_rb", rb, 4'b0001);
        chk("extest_ir", ir_out, 4'h0);
        chk("extest_sel_mode", {bsr_select, mode}, 2'b11);

        // TLR from RTI also restores the reset instruction
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
        chk("tlr_ir_after_extest", ir_out, IR_RST);
        chk("tlr_mode_after_extest", mode, 1'b0);
        tck(1'b0, 1'b0);

        // SAMPLE: strobes and BSR routing
        ir_load(4'h1, rb);
        chk("sample_rb", rb, 4'b0001);
        chk("sample_sel_mode", {bsr_select, mode}, 2'b10);
        tck(1'b1, 1'b0);  // SEL_DR
        chk("seldr_no_cap", dr_capture, 1'b0);
        tck(1'b0, 1'b0);  // CAP_DR
        chk("cap_strobe", {dr_capture, dr_shift, dr_update}, 3'b100);
        bsr_tdo   = 1'b1;
        shift_cnt = 0;
        tck(1'b0, 1'b0);  // SHIFT_DR
        if (dr_shift) shift_cnt++;
        chk("shift_strobe", {dr_capture, dr_shift, dr_update}, 3'b010);
        chk("shift_tdo_en", jtag.tdo_en, 1'b1);
        chk("shift_bsr_tdo1", jtag.TDO, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bsr_tdo = k[0];
            tck(k == 2, 1'b0);
            if (dr_shift) shift_cnt++;
            if (k < 2) chk("shift_bsr_tdo", jtag.TDO, k[0]);
        end
        chk("shift_cycles", shift_cnt, 3);
        chk("exit1_tdo_hold", jtag.TDO, 1'b1);
        chk("exit1_tdo_en", jtag.tdo_en, 1'b0);
        tck(1'b1, 1'b0);  // UPD_DR
        chk("upd_strobe", {dr_capture, dr_shift, dr_update}, 3'b001);
        chk("upd_mode", mode, 1'b0);
        tck(1'b0, 1'b0);  // RTI
        chk("rti_no_upd", dr_update, 1'b0);

        // Explicit BYPASS
        ir_load(4'hF, rb);
        chk("bypass_sel", bsr_select, 1'b0);
        dr_scan(9, 64'h0CD, dout);
        chk("bypass_scan", dout[8:0], 9'b110011010);

        // Unused opcode acts as bypass
        ir_load(4'h5, rb);
        chk("op5_sel_mode", {bsr_select, mode}, 2'b00);
        dr_scan(9, 64'h1A5, dout);
        chk("op5_bypass_scan", dout[8:0], 9'b101001010);

        // IDCODE opcode
        ir_load(4'h2, rb);
        chk("idop_sel", bsr_select, 1'b0);
`ifdef TAP_IDCODE_EN
        dr_scan(32, 64'h0, dout);
        chk("idop_scan", dout[31:0], ID_VAL);
`else
        dr_scan(9, 64'h0CD, dout);
        chk("idop_bypass_scan", dout[8:0], 9'b110011010);
`endif

        // TRST mid-SHIFT_DR
        ir_load(4'h0, rb);
        bsr_tdo = 1'b1;
        tck(1'b1, 1'b0);  // SEL_DR
        tck(1'b0, 1'b0);  // CAP_DR
        tck(1'b0, 1'b0);  // SHIFT_DR
        chk("pre_trst_shift", dr_shift, 1'b1);
        chk("pre_trst_tdo", jtag.TDO, 1'b1);
        #3;
        TRST = 1'b0;
        #1;
        chk("trst_tlr", tlr_reset, 1'b1);
        chk("trst_no_shift", dr_shift, 1'b0);
        chk("trst_ir", ir_out, IR_RST);
        chk("trst_tdo", jtag.TDO, 1'b0);
        chk("trst_tdo_en", jtag.tdo_en, 1'b0);
        chk("trst_mode", mode, 1'b0);
        @(negedge TCK);
        TRST = 1'b1;
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
